ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, PC value loaded on reset; ADDR_W, 14, word-address width of instruction memory.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  one clock; reset is synchronous and active-low.
REQ-004 stall  in  1  hold current PC/instruction this cycle.
REQ-005 branch, zero  in  1 each  beq decoded / ALU equality result; branch taken = branch & zero.
REQ-006 jal, jalr  in  1 each  jump decoded.
REQ-007 imm32  in  32  sign-extended immediate from decode stage.
REQ-008 rs1Data  in  32  register-file rs1 value, used for jalr.
REQ-009 halt  in  1  ecall/halt decoded for the current instruction.
REQ-010 resume  in  1  restart request, e.g. button, while halted.
REQ-011 imemAddr  out  ADDR_W  word address to synchronous instruction ROM with 1-cycle read latency.
REQ-012 imemData  in  32  ROM data for the address presented in the previous cycle.
REQ-013 inst  out  32  current instruction to decode stage.
REQ-014 pc, pcPlus4  out  32 each  current PC and PC+4, the link value.
REQ-015 instValid  out  1  inst is a real fetched instruction.
REQ-016 halted, misaligned  out  1 each  status flags.
REQ-017 retired  out  32  count of instructions retired.

Function
REQ-018 FSM SHALL have states BOOT, RUN, HALT.
REQ-019 BOOT SHALL last exactly one cycle, present imemAddr = RESET_PC[ADDR_W+1:2], then go to RUN.
REQ-020 imemAddr SHALL be combinational: in RUN with advance, the next-PC word; otherwise the current pc word, so imemData always matches the pc register.
REQ-021 Advance = (state==RUN) & ~stall & ~target misaligned.
REQ-022 Next PC SHALL follow priority jalr > jal > taken branch > sequential: jalr gives (rs1Data+imm32) & ~32'h1; jal or taken branch gives pc+imm32; otherwise pc+4.
REQ-023 All PC arithmetic SHALL be modulo 2^32; imemAddr SHALL use pc[ADDR_W+1:2] only, and upper bits alias.
REQ-024 A selected target with bit 1 set, in RUN & ~stall, SHALL hold pc, set misaligned (sticky until reset), and enter HALT next edge.
REQ-025 halt=1 in RUN & ~stall SHALL advance pc normally once and enter HALT next edge; stall=1 SHALL mask halt.
REQ-026 In HALT, pc SHALL hold; resume=1 SHALL return to RUN next edge; resume outside HALT SHALL be ignored.
REQ-027 inst SHALL equal imemData in RUN, otherwise 32'h0000_0013 (nop); instValid = (state==RUN); halted = (state==HALT).
REQ-028 pcPlus4 SHALL always equal pc+4 combinationally.
REQ-029 retired SHALL increment by 1 on each edge where advance=1, and SHALL wrap at 2^32.
REQ-030 stall and branch/jump asserted together SHALL ignore the redirect, with pc held.

Reset
REQ-031 rst=0 at a clock edge SHALL set pc=RESET_PC, state=BOOT, retired=0, misaligned=0, with priority over all other inputs including mid-HALT or mid-stall.
REQ-032 During and one cycle after reset, instValid=0 and inst=32'h0000_0013.

Verification
REQ-033 Reset release, ROM word0=0x00500093 -> cycle 1 BOOT, instValid=0; cycle 2 pc=0, inst=0x00500093, instValid=1; cycle 3 pc=4, retired=1.
REQ-034 At pc=0x10: branch=1, zero=1, imm32=0xFFFFFFF8 -> next pc=0x08; zero=0 -> next pc=0x14.
REQ-035 At pc=0x20: jalr=1, jal=1, rs1Data=0x101, imm32=0x4 -> next pc=0x104 (jalr wins, bit0 cleared); pcPlus4=0x24.
REQ-036 At pc=0x30: jal=1, imm32=0x6 -> pc stays 0x30, misaligned=1, halted=1 next cycle, retired unchanged.
REQ-037 At pc=0x40: stall=1 with halt=1 for 3 cycles -> pc=0x40, state RUN; release stall with halt=1 -> pc=0x44, HALT; resume=1 -> RUN, inst=ROM[0x44].
REQ-038 pc=0xFFFF_FFFC sequential -> pc=0x0000_0000; rst=0 while in HALT -> next cycle BOOT, pc=RESET_PC, retired=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC sequencing (BOOT/RUN/HALT), next-PC select, sync-ROM addressing, retire counter.
// Latency: imemAddr is combinational toward a 1-cycle ROM; stall holds pc/inst with no redirect.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 14
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic              zero_i,
   input  logic              jal_i,
   input  logic              jalr_i,
   input  logic [31:0]       imm32_i,
   input  logic [31:0]       rs1Data_i,
   input  logic              halt_i,
   input  logic              resume_i,
   output logic [ADDR_W-1:0] imemAddr_o,
   input  logic [31:0]       imemData_i,
   output logic [31:0]       inst_o,
   output logic [31:0]       pc_o,
   output logic [31:0]       pcPlus4_o,
   output logic              instValid_o,
   output logic              halted_o,
   output logic              misaligned_o,
   output logic [31:0]       retired_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] retired_q;
   logic        misaligned_q;

   logic [31:0] pc_d;
   logic        tgt_mis;
   logic        advance;

   // jalr > jal > taken branch > sequential
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (jalr_i) begin
         pc_d = (rs1Data_i + imm32_i) & ~32'h1;
      end else if (jal_i || (branch_i && zero_i)) begin
         pc_d = pc_q + imm32_i;
      end
   end

   assign tgt_mis = pc_d[1];
   assign advance = (state_q == RUN) && !stall_i && !tgt_mis;

   // Present the next PC early so the ROM output lines up with pc_q after the edge.
   assign imemAddr_o = advance ? pc_d[ADDR_W+1:2] : pc_q[ADDR_W+1:2];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         retired_q    <= 32'd0;
         misaligned_q <= 1'b0;
      end else begin
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (!stall_i) begin
                  if (tgt_mis) begin
                     misaligned_q <= 1'b1;
                     state_q      <= HALT;
                  end else begin
                     pc_q      <= pc_d;
                     retired_q <= retired_q + 32'd1;
                     if (halt_i) state_q <= HALT;
                  end
               end
            end
            HALT: if (resume_i) state_q <= RUN;
            default: state_q <= BOOT;
         endcase
      end
   end

   assign inst_o       = (state_q == RUN) ? imemData_i : NOP;
   assign pc_o         = pc_q;
   assign pcPlus4_o    = pc_q + 32'd4;
   assign instValid_o  = (state_q == RUN);
   assign halted_o     = (state_q == HALT);
   assign misaligned_o = misaligned_q;
   assign retired_o    = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random control traffic against a cycle-level reference model.
module tb_ifetch_unit;

   localparam int AW = 14;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

   logic          clk = 1'b0;
   logic          rst_n, stall, branch, zero, jal, jalr, halt, resume;
   logic [31:0]   imm32, rs1;
   logic [AW-1:0] imemAddr;
   logic [31:0]   imemData, inst, pc, pcPlus4, retired;
   logic          instValid, halted, misaligned;

   logic [31:0] rom [0:(1<<AW)-1];

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          m_st;
   logic [31:0] m_pc, m_ret;
   logic        m_mis;
   bit          m_ok = 0;

   ifetch_unit #(.RESET_PC(32'h0), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_i(branch), .zero_i(zero),
      .jal_i(jal), .jalr_i(jalr), .imm32_i(imm32), .rs1Data_i(rs1), .halt_i(halt),
      .resume_i(resume), .imemAddr_o(imemAddr), .imemData_i(imemData), .inst_o(inst),
      .pc_o(pc), .pcPlus4_o(pcPlus4), .instValid_o(instValid), .halted_o(halted),
      .misaligned_o(misaligned), .retired_o(retired)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) imemData <= rom[imemAddr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] target();
      if (jalr) return (rs1 + imm32) & ~32'h1;
      if (jal || (branch && zero)) return m_pc + imm32;
      return m_pc + 32'd4;
   endfunction

   task automatic model_edge();
      logic [31:0] t;
      t = target();
      if (!rst_n) begin
         m_st = M_BOOT; m_pc = 32'h0; m_ret = 0; m_mis = 0; m_ok = 1;
      end else if (m_st == M_BOOT) begin
         m_st = M_RUN;
      end else if (m_st == M_RUN && !stall) begin
         if (t[1]) begin
            m_mis = 1; m_st = M_HALT;
         end else begin
            m_pc = t; m_ret = m_ret + 1;
            if (halt) m_st = M_HALT;
         end
      end else if (m_st == M_HALT && resume) begin
         m_st = M_RUN;
      end
   endtask

   task automatic check_outputs();
      chk("pc", pc, m_pc);
      chk("pcPlus4", pcPlus4, m_pc + 32'd4);
      chk("instValid", {31'b0, instValid}, {31'b0, m_st == M_RUN});
      chk("halted", {31'b0, halted}, {31'b0, m_st == M_HALT});
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      chk("retired", retired, m_ret);
      chk("inst", inst, (m_st == M_RUN) ? rom[m_pc[AW+1:2]] : NOP);
   endtask

   // one clock: drive inputs after negedge, check address, step edge, check outputs
   task automatic cyc(input logic r, input logic s, input logic b, input logic z,
                      input logic jl, input logic jr, input logic h, input logic rs,
                      input logic [31:0] im, input logic [31:0] r1);
      logic [31:0] t;
      logic [AW-1:0] exp_addr;
      rst_n = r; stall = s; branch = b; zero = z; jal = jl; jalr = jr;
      halt = h; resume = rs; imm32 = im; rs1 = r1;
      #1;
      if (m_ok) begin
         t = target();
         exp_addr = (m_st == M_RUN && !stall && !t[1]) ? t[AW+1:2] : m_pc[AW+1:2];
         chk("imemAddr", {{(32-AW){1'b0}}, imemAddr}, {{(32-AW){1'b0}}, exp_addr});
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic go_to(input logic [31:0] dest);
      cyc(1, 0, 0, 0, 1, 0, 0, 0, dest - m_pc, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
      rom[0] = 32'h0050_0093;
      rst_n = 0; stall = 0; branch = 0; zero = 0; jal = 0; jalr = 0;
      halt = 0; resume = 0; imm32 = 0; rs1 = 0;
      @(negedge clk);

      // reset and boot sequence
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 1, 0, 1, 1, 32'h40, 0);
      chk("rst_valid", {31'b0, instValid}, 32'h0);
      chk("rst_inst", inst, NOP);
      idle();
      chk("boot_pc", pc, 32'h0);
      chk("boot_inst", inst, 32'h0050_0093);
      chk("boot_valid", {31'b0, instValid}, 32'h1);
      idle();
      chk("first_pc", pc, 32'h4);
      chk("first_ret", retired, 32'h1);

      // branch taken / not taken
      go_to(32'h10);
      cyc(1, 0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0);
      chk("br_taken", pc, 32'h08);
      go_to(32'h10);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0);
      chk("br_nottaken", pc, 32'h14);

      // jalr beats jal, bit0 cleared
      go_to(32'h20);
      chk("link", pcPlus4, 32'h24);
      cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h4, 32'h101);
      chk("jalr_prio", pc, 32'h104);

      // misaligned jal target
      go_to(32'h30);
      begin
         logic [31:0] r0;
         r0 = retired;
         cyc(1, 0, 0, 0, 1, 0, 0, 0, 32'h6, 0);
         chk("mis_pc", pc, 32'h30);
         chk("mis_flag", {31'b0, misaligned}, 32'h1);
         chk("mis_halt", {31'b0, halted}, 32'h1);
         chk("mis_ret", retired, r0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // stall masks halt; then halt; resume
      go_to(32'h40);
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 1, 0, 1, 0, 32'h8, 0);
      chk("stall_pc", pc, 32'h40);
      chk("stall_run", {31'b0, instValid}, 32'h1);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("halt_pc", pc, 32'h44);
      chk("halt_st", {31'b0, halted}, 32'h1);
      idle();
      chk("halt_hold", pc, 32'h44);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("resume_inst", inst, rom[17]);

      // wrap and reset-in-HALT
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC);
      chk("top_pc", pc, 32'hFFFF_FFFC);
      idle();
      chk("wrap_pc", pc, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rst_halt_pc", pc, 32'h0);
      chk("rst_halt_ret", retired, 32'h0);
      chk("rst_halt_st", {31'b0, halted | instValid}, 32'h0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] im, r1;
         im = ($urandom_range(0, 127) * 4) - 32'd256;
         if ($urandom_range(0, 9) == 0) im = im + 32'd2;
         r1 = $urandom & ~32'h3;
         if ($urandom_range(0, 9) == 0) r1 = r1 | 32'h2;
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, im, r1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
